// File: rtl/dds_wave_shaper.sv
// DDS wave shaper: phase code to signed amplitude through a 4-stage pipeline.
// Sine uses quarter-wave folding into an external synchronous ROM; other shapes are arithmetic.
module dds_wave_shaper #(
    parameter int PHASE_W = 11,
    parameter int DATA_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PHASE_W-1:0]   phase_in,
    input  logic                 phase_vld,
    input  logic [1:0]           wave_sel,
    input  logic [7:0]           gain,
    output logic [PHASE_W-3:0]   rom_addr,
    output logic                 rom_rd_en,
    input  logic [DATA_W-2:0]    rom_data,
    output logic [DATA_W-1:0]    wave_out,
    output logic                 wave_vld
);

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

    localparam int PROD_W   = DATA_W + 9;
    localparam int SAT_HI_I = 2 ** (DATA_W - 1) - 1;
    localparam int SAT_LO_I = -(2 ** (DATA_W - 1));

    localparam logic [DATA_W-1:0] SQ_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SQ_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    logic                s1_vld_q, s2_vld_q, s3_vld_q;
    logic [PHASE_W-1:0]  s1_phase_q, s2_phase_q;
    wave_e               s1_sel_q, s2_sel_q;
    logic [7:0]          s1_gain_q, s2_gain_q, s3_gain_q;
    logic [DATA_W-1:0]   s3_sample_q, s3_sample_d;
    logic [DATA_W-1:0]   wave_out_q, wave_out_d;
    logic                wave_vld_q;

    logic [1:0]          s1_quad;
    logic [PHASE_W-3:0]  s1_idx;
    logic [DATA_W-1:0]   sine_mag;
    logic [PHASE_W-2:0]  tri_t;
    logic [DATA_W-1:0]   tri_s, saw_s, sqr_s, sine_s;

    logic signed [DATA_W-1:0] sample_s;
    logic signed [8:0]        gain_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    int                       shifted_i;

    // Odd quadrants walk the quarter-wave table backwards.
    always_comb begin
        s1_quad   = s1_phase_q[PHASE_W-1 -: 2];
        s1_idx    = s1_phase_q[PHASE_W-3:0];
        rom_addr  = s1_quad[0] ? ~s1_idx : s1_idx;
        rom_rd_en = s1_vld_q;
    end

    always_comb begin
        sine_mag = {1'b0, rom_data};
        sine_s   = s2_phase_q[PHASE_W-1] ? ('0 - sine_mag) : sine_mag;
        tri_t    = s2_phase_q[PHASE_W-1] ? ~s2_phase_q[PHASE_W-2:0] : s2_phase_q[PHASE_W-2:0];
        tri_s    = {~tri_t[PHASE_W-2], tri_t[PHASE_W-3 -: DATA_W-1]};
        saw_s    = {~s2_phase_q[PHASE_W-1], s2_phase_q[PHASE_W-2 -: DATA_W-1]};
        sqr_s    = s2_phase_q[PHASE_W-1] ? SQ_NEG : SQ_POS;
        s3_sample_d = sine_s;
        case (s2_sel_q)
            WAVE_SINE: s3_sample_d = sine_s;
            WAVE_TRI:  s3_sample_d = tri_s;
            WAVE_SAW:  s3_sample_d = saw_s;
            WAVE_SQR:  s3_sample_d = sqr_s;
            default:   s3_sample_d = sine_s;
        endcase
    end

    // Gain is Q1.7 (128 = unity); the shift floors toward minus infinity.
    always_comb begin
        sample_s  = s3_sample_q;
        gain_s    = {1'b0, s3_gain_q};
        prod      = PROD_W'(sample_s) * PROD_W'(gain_s);
        shifted   = prod >>> 7;
        shifted_i = int'(shifted);
        wave_out_d = wave_out_q;
        if (s3_vld_q) begin
            if (shifted_i > SAT_HI_I)
                wave_out_d = DATA_W'(SAT_HI_I);
            else if (shifted_i < SAT_LO_I)
                wave_out_d = DATA_W'(SAT_LO_I);
            else
                wave_out_d = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            s1_phase_q  <= '0;
            s2_phase_q  <= '0;
            s1_sel_q    <= WAVE_SINE;
            s2_sel_q    <= WAVE_SINE;
            s1_gain_q   <= '0;
            s2_gain_q   <= '0;
            s3_gain_q   <= '0;
            s3_sample_q <= '0;
            wave_out_q  <= '0;
            wave_vld_q  <= 1'b0;
        end else begin
            s1_vld_q    <= phase_vld;
            s1_phase_q  <= phase_in;
            s1_sel_q    <= wave_e'(wave_sel);
            s1_gain_q   <= gain;
            s2_vld_q    <= s1_vld_q;
            s2_phase_q  <= s1_phase_q;
            s2_sel_q    <= s1_sel_q;
            s2_gain_q   <= s1_gain_q;
            s3_vld_q    <= s2_vld_q;
            s3_sample_q <= s3_sample_d;
            s3_gain_q   <= s2_gain_q;
            wave_out_q  <= wave_out_d;
            wave_vld_q  <= s3_vld_q;
        end
    end

    assign wave_out = wave_out_q;
    assign wave_vld = wave_vld_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Directed bench for dds_wave_shaper: expected samples and ROM addresses are queued at drive
// time and checked when the DUT produces them, against a behavioural ROM and wave model.
module tb_dds_wave_shaper;

    localparam int PW = 11;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phase_in = '0;
    logic          phase_vld = 1'b0;
    logic [1:0]    wave_sel = '0;
    logic [7:0]    gain = '0;
    logic [PW-3:0] rom_addr;
    logic          rom_rd_en;
    logic [DW-2:0] rom_data = '0;
    logic [DW-1:0] wave_out;
    logic          wave_vld;

    dds_wave_shaper #(.PHASE_W(PW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_in  (phase_in),
        .phase_vld (phase_vld),
        .wave_sel  (wave_sel),
        .gain      (gain),
        .rom_addr  (rom_addr),
        .rom_rd_en (rom_rd_en),
        .rom_data  (rom_data),
        .wave_out  (wave_out),
        .wave_vld  (wave_vld)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int due; int ph; } wexp_t;
    typedef struct { int addr; int due; } aexp_t;

    wexp_t wq[$];
    aexp_t aq[$];
    wexp_t w_cur;
    aexp_t a_cur;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_exp = 0;
    bit    rec = 1'b0;
    int    rom[512];
    int    sweep_out[2048];

    initial begin
        for (int i = 0; i < 512; i++)
            rom[i] = $rtoi(511.0 * $sin(3.14159265358979 * (i + 0.5) / 1024.0) + 0.5);
        for (int i = 0; i < 2048; i++)
            sweep_out[i] = 0;
    end

    always @(posedge clk) begin
        if (rom_rd_en)
            rom_data <= 9'(rom[rom_addr]);
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model(input int p, input int sel, input int g);
        int s, r, q, i;
        q = p / 512;
        i = p % 512;
        case (sel)
            0: begin
                s = rom[(q % 2 == 1) ? 511 - i : i];
                if (q >= 2) s = -s;
            end
            1: s = ((p < 1024) ? p : 2047 - p) - 512;
            2: s = p / 2 - 512;
            default: s = (p < 1024) ? 511 : -511;
        endcase
        r = (s * g) >>> 7;
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    function automatic int addr_model(input int p);
        int q, i;
        q = p / 512;
        i = p % 512;
        return (q % 2 == 1) ? 511 - i : i;
    endfunction

    // Output monitor: pops the scoreboard whenever the DUT presents a read strobe or a sample.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (rom_rd_en) begin
                if (aq.size() == 0) chk("rom_rd_en_spurious", 1, 0);
                else begin
                    a_cur = aq.pop_front();
                    chk("rom_rd_latency", cyc, a_cur.due);
                    chk("rom_addr", rom_addr, a_cur.addr);
                end
            end else if (aq.size() > 0 && aq[0].due <= cyc) begin
                chk("rom_rd_en_missing", 0, 1);
                a_cur = aq.pop_front();
            end

            if (wave_vld) begin
                if (wq.size() == 0) chk("wave_vld_spurious", 1, 0);
                else begin
                    w_cur = wq.pop_front();
                    chk("wave_latency", cyc, w_cur.due);
                    chk("wave_out", $signed(wave_out), w_cur.val);
                    last_exp = w_cur.val;
                    if (rec) sweep_out[w_cur.ph] = $signed(wave_out);
                end
            end else begin
                chk("wave_out_hold", $signed(wave_out), last_exp);
                if (wq.size() > 0 && wq[0].due <= cyc) begin
                    chk("wave_vld_missing", 0, 1);
                    w_cur = wq.pop_front();
                end
            end
        end
    end

    task automatic send(input int p, input int sel, input int g);
        @(negedge clk);
        phase_in  = PW'(p);
        wave_sel  = 2'(sel);
        gain      = 8'(g);
        phase_vld = 1'b1;
        aq.push_back('{addr: addr_model(p), due: cyc + 1});
        wq.push_back('{val: model(p, sel, g), due: cyc + 4, ph: p});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            phase_vld = 1'b0;
            phase_in  = PW'($urandom);
            wave_sel  = 2'($urandom);
            gain      = 8'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_wave_out", $signed(wave_out), 0);
        chk("reset_wave_vld", wave_vld, 0);
        chk("reset_rom_rd_en", rom_rd_en, 0);
        chk("reset_rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        idle(2);

        send(12'h000, 0, 128); idle(1);
        send(12'h200, 0, 128); idle(1);
        send(12'h400, 0, 128); idle(1);
        send(12'h7FF, 0, 128); idle(5);

        send(12'h000, 1, 128); send(12'h3FF, 1, 128);
        send(12'h400, 1, 128); send(12'h7FF, 1, 128);
        send(12'h000, 2, 128); send(12'h7FF, 2, 128);
        send(12'h3FF, 3, 128); send(12'h400, 3, 128);
        idle(5);

        send(12'h3FF, 3, 64);  send(12'h400, 3, 64);
        send(12'h3FF, 3, 0);   send(12'h400, 3, 0);
        send(12'h3FF, 3, 255); send(12'h400, 3, 255);
        send(12'h000, 2, 255);
        idle(5);

        for (int k = 0; k < 20; k++)
            send(int'($urandom_range(0, 2047)), k % 4, int'($urandom_range(0, 255)));
        idle(3);
        send(12'h123, 1, 200);
        idle(6);

        send(12'h100, 3, 128);
        idle(5);
        send(12'h500, 3, 128); send(12'h080, 0, 128); send(12'h600, 2, 128);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wave_out", $signed(wave_out), 0);
        chk("midrst_wave_vld", wave_vld, 0);
        chk("midrst_rom_rd_en", rom_rd_en, 0);
        phase_vld = 1'b0;
        wq.delete();
        aq.delete();
        last_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_reset_vld", wave_vld, 0);
        end

        rec = 1'b1;
        for (int p = 0; p < 2048; p++)
            send(p, 0, 128);
        idle(8);
        rec = 1'b0;
        for (int p = 0; p < 1024; p++)
            chk("odd_symmetry", sweep_out[p + 1024], -sweep_out[p]);

        chk("scoreboard_drained", wq.size() + aq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
